pipe_hazard_ctrl: RTL and testbench

- Stall/flush sequencer for the 5-stage pipeline with branch resolution in ID.
- Takes register addresses and control bits from the ID, EX and MEM stages.
- Drives the PC enable (pc_enable_hbu), the IF/ID hold and flush, the ID/EX bubble, and branch-comparator forwarding selects.
- Registered stall countdown FSM; replaces per-cycle ad-hoc stall logic and honours the external run enable.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/hazard_detect.sv | 53 +++++
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and limits for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } ctrl_state_e;

  localparam int unsigned RA_ZERO   = 0;
  localparam int unsigned MAX_STALL = 2;

  function automatic int unsigned stall_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard scan: stall length needed by the ID instruction and
// branch-comparator forwarding selects from the MEM ALU result.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 2
) (
  input  logic [RA_W-1:0]  i_id_rs,
  input  logic [RA_W-1:0]  i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_id_branch,
  input  logic             i_id_jump,
  input  logic             i_ex_reg_we,
  input  logic             i_ex_mem_rd,
  input  logic [RA_W-1:0]  i_ex_waddr,
  input  logic             i_mem_reg_we,
  input  logic             i_mem_mem_rd,
  input  logic [RA_W-1:0]  i_mem_waddr,
  output logic [CNT_W-1:0] o_n,
  output logic             o_fwd_br_a,
  output logic             o_fwd_br_b
);

  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_ex_any, w_mem_any;
  int unsigned w_n;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign w_ex_rs  = i_ex_reg_we && (i_ex_waddr != RA_W'(RA_ZERO)) && i_id_use_rs && (i_ex_waddr == i_id_rs);
  assign w_ex_rt  = i_ex_reg_we && (i_ex_waddr != RA_W'(RA_ZERO)) && i_id_use_rt && (i_ex_waddr == i_id_rt);
  assign w_mem_rs = i_mem_reg_we && (i_mem_waddr != RA_W'(RA_ZERO)) && i_id_use_rs && (i_mem_waddr == i_id_rs);
  assign w_mem_rt = i_mem_reg_we && (i_mem_waddr != RA_W'(RA_ZERO)) && i_id_use_rt && (i_mem_waddr == i_id_rt);
  assign w_ex_any  = w_ex_rs || w_ex_rt;
  assign w_mem_any = w_mem_rs || w_mem_rt;

  always_comb begin
    w_n = 0;
    if (i_ex_mem_rd && w_ex_any)
      w_n = stall_max(w_n, 1);
    if ((i_id_branch || i_id_jump) && !i_ex_mem_rd && w_ex_any)
      w_n = stall_max(w_n, 1);
    if (i_id_branch && i_ex_mem_rd && w_ex_any)
      w_n = stall_max(w_n, MAX_STALL);
    if (i_id_branch && i_mem_mem_rd && w_mem_any)
      w_n = stall_max(w_n, 1);
  end

  assign o_n        = CNT_W'(w_n);
  assign o_fwd_br_a = i_id_branch && w_mem_rs && !i_mem_mem_rd;
  assign o_fwd_br_b = i_id_branch && w_mem_rt && !i_mem_mem_rd;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline resolving branches in ID.
// Optional HAZARD_PERF_EN adds saturating stall_cycles/flush_count outputs.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 2
) (
  input  logic            p_clk,
  input  logic            p_rst_s,
  input  logic            pc_enable,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_branch,
  input  logic            id_taken,
  input  logic            id_jump,
  input  logic            ex_reg_we,
  input  logic            ex_mem_rd,
  input  logic [RA_W-1:0] ex_waddr,
  input  logic            mem_reg_we,
  input  logic            mem_mem_rd,
  input  logic [RA_W-1:0] mem_waddr,
  output logic            pc_enable_hbu,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            fwd_br_a,
  output logic            fwd_br_b,
`ifdef HAZARD_PERF_EN
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count,
`endif
  output logic [1:0]      ctrl_state
);

  ctrl_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_n;
  logic             w_fwd_a, w_fwd_b, w_redirect;
  logic             w_pc, w_we, w_flush, w_bubble;

  hazard_detect #(.RA_W(RA_W), .CNT_W(CNT_W)) u_hazard_detect (
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_use_rs  (id_use_rs),
    .i_id_use_rt  (id_use_rt),
    .i_id_branch  (id_branch),
    .i_id_jump    (id_jump),
    .i_ex_reg_we  (ex_reg_we),
    .i_ex_mem_rd  (ex_mem_rd),
    .i_ex_waddr   (ex_waddr),
    .i_mem_reg_we (mem_reg_we),
    .i_mem_mem_rd (mem_mem_rd),
    .i_mem_waddr  (mem_waddr),
    .o_n          (w_n),
    .o_fwd_br_a   (w_fwd_a),
    .o_fwd_br_b   (w_fwd_b)
  );

  assign w_redirect = (id_branch && id_taken) || id_jump;

  // RUN is Mealy so a hazard bubbles in the cycle it is seen; other states are Moore.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc        = 1'b0;
    w_we        = 1'b0;
    w_flush     = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!pc_enable) begin
          w_state_nxt = ST_HALT;
        end else if (w_n != '0) begin
          w_bubble    = 1'b1;
          w_state_nxt = ST_STALL;
          w_cnt_nxt   = w_n - CNT_W'(1);
        end else if (w_redirect) begin
          w_pc        = 1'b1;
          w_we        = 1'b1;
          w_flush     = 1'b1;
          w_state_nxt = ST_FLUSH;
        end else begin
          w_pc = 1'b1;
          w_we = 1'b1;
        end
      end
      ST_STALL: begin
        if (pc_enable) begin
          w_bubble = 1'b1;
          if (r_cnt != '0) w_cnt_nxt   = r_cnt - CNT_W'(1);
          else             w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (pc_enable) begin
          w_pc        = 1'b1;
          w_we        = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        if (pc_enable) w_state_nxt = ST_RUN;
      end
    endcase
    if (p_rst_s) begin
      w_pc     = 1'b0;
      w_we     = 1'b0;
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_rst_s) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pc_enable_hbu = w_pc;
  assign ifid_we       = w_we;
  assign ifid_flush    = w_flush;
  assign idex_bubble   = w_bubble;
  assign fwd_br_a      = w_fwd_a && !p_rst_s;
  assign fwd_br_b      = w_fwd_b && !p_rst_s;
  assign ctrl_state    = r_state;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles, r_flush_count;

  always_ff @(posedge p_clk) begin
    if (p_rst_s) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_bubble && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush && (r_flush_count != '1))   r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle reference model.
module tb_pipe_hazard_ctrl;

  logic       p_clk = 1'b0;
  logic       p_rst_s, pc_enable;
  logic [4:0] id_rs, id_rt, ex_waddr, mem_waddr;
  logic       id_use_rs, id_use_rt, id_branch, id_taken, id_jump;
  logic       ex_reg_we, ex_mem_rd, mem_reg_we, mem_mem_rd;
  logic       pc_enable_hbu, ifid_we, ifid_flush, idex_bubble, fwd_br_a, fwd_br_b;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipe_hazard_ctrl #(.RA_W(5), .CNT_W(2)) dut (
    .p_clk         (p_clk),
    .p_rst_s       (p_rst_s),
    .pc_enable     (pc_enable),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_use_rs),
    .id_use_rt     (id_use_rt),
    .id_branch     (id_branch),
    .id_taken      (id_taken),
    .id_jump       (id_jump),
    .ex_reg_we     (ex_reg_we),
    .ex_mem_rd     (ex_mem_rd),
    .ex_waddr      (ex_waddr),
    .mem_reg_we    (mem_reg_we),
    .mem_mem_rd    (mem_mem_rd),
    .mem_waddr     (mem_waddr),
    .pc_enable_hbu (pc_enable_hbu),
    .ifid_we       (ifid_we),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .fwd_br_a      (fwd_br_a),
    .fwd_br_b      (fwd_br_b),
`ifdef HAZARD_PERF_EN
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
`endif
    .ctrl_state    (ctrl_state)
  );

  always #5 p_clk = ~p_clk;

  int n_pass  = 0;
  int n_total = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
  endtask

  // Model: remaining stall cycles, pending flush cycle, halted flag.
  int m_stall_left = 0;
  bit m_flush = 0, m_halt = 0, m_known = 0;

  function automatic int model_n();
    int n = 0;
    int src[2];
    bit use_s[2];
    src[0] = id_rs; use_s[0] = id_use_rs;
    src[1] = id_rt; use_s[1] = id_use_rt;
    for (int k = 0; k < 2; k++) begin
      if (use_s[k] && src[k] != 0) begin
        if (ex_reg_we && ex_waddr == src[k]) begin
          if (ex_mem_rd) n = (id_branch && n < 2) ? 2 : (n < 1 ? 1 : n);
          else if ((id_branch || id_jump) && n < 1) n = 1;
        end
        if (mem_reg_we && mem_mem_rd && mem_waddr == src[k] && id_branch && n < 1) n = 1;
      end
    end
    return n;
  endfunction

  always @(posedge p_clk) begin
    if (p_rst_s === 1'b1) begin
      m_stall_left = 0; m_flush = 0; m_halt = 0; m_known = 1;
    end else if (m_known) begin
      if (m_halt) begin
        if (pc_enable) m_halt = 0;
      end else if (m_stall_left > 0) begin
        if (pc_enable) m_stall_left--;
      end else if (m_flush) begin
        if (pc_enable) m_flush = 0;
      end else if (!pc_enable) begin
        m_halt = 1;
      end else if (model_n() > 0) begin
        m_stall_left = model_n();
      end else if ((id_branch && id_taken) || id_jump) begin
        m_flush = 1;
      end
    end
  end

  always @(negedge p_clk) begin
    if (run_cmp) begin
      int e_pc, e_we, e_fl, e_bub, e_fa, e_fb, e_st;
      e_pc = 0; e_we = 0; e_fl = 0; e_bub = 0; e_fa = 0; e_fb = 0;
      e_st = m_halt ? 3 : (m_stall_left > 0) ? 1 : m_flush ? 2 : 0;
      if (p_rst_s) begin
        e_fl = 1; e_bub = 1;
      end else begin
        e_fa = (id_branch && mem_reg_we && !mem_mem_rd && id_use_rs && mem_waddr != 0 && mem_waddr == id_rs) ? 1 : 0;
        e_fb = (id_branch && mem_reg_we && !mem_mem_rd && id_use_rt && mem_waddr != 0 && mem_waddr == id_rt) ? 1 : 0;
        if (!m_halt && pc_enable) begin
          if (m_stall_left > 0) e_bub = 1;
          else if (m_flush) begin e_pc = 1; e_we = 1; end
          else if (model_n() > 0) e_bub = 1;
          else begin
            e_pc = 1; e_we = 1;
            e_fl = ((id_branch && id_taken) || id_jump) ? 1 : 0;
          end
        end
      end
      chk("cmp_pc_enable_hbu", int'(pc_enable_hbu), e_pc);
      chk("cmp_ifid_we", int'(ifid_we), e_we);
      chk("cmp_ifid_flush", int'(ifid_flush), e_fl);
      chk("cmp_idex_bubble", int'(idex_bubble), e_bub);
      chk("cmp_fwd_br_a", int'(fwd_br_a), e_fa);
      chk("cmp_fwd_br_b", int'(fwd_br_b), e_fb);
      if (m_known) chk("cmp_ctrl_state", int'(ctrl_state), e_st);
    end
  end

  task automatic clear();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_branch = 0; id_taken = 0; id_jump = 0;
    ex_reg_we = 0; ex_mem_rd = 0; ex_waddr = 0;
    mem_reg_we = 0; mem_mem_rd = 0; mem_waddr = 0;
  endtask

  task automatic step();
    @(posedge p_clk);
    #1;
  endtask

  initial begin
    p_rst_s = 1; pc_enable = 1; clear();
    #1;
    run_cmp = 1;
    chk("rst_pc", int'(pc_enable_hbu), 0);
    chk("rst_ifid_we", int'(ifid_we), 0);
    chk("rst_flush", int'(ifid_flush), 1);
    chk("rst_bubble", int'(idex_bubble), 1);
    step(); step();
    p_rst_s = 0; #1;
    chk("run_state", int'(ctrl_state), 0);
    chk("run_pc", int'(pc_enable_hbu), 1);
    chk("run_we", int'(ifid_we), 1);
    chk("run_flush", int'(ifid_flush), 0);
    step();

    // Load-use: EX lw $8, ID add reads $8.
    ex_reg_we = 1; ex_mem_rd = 1; ex_waddr = 8; id_rs = 8; id_use_rs = 1; #1;
    chk("lu_pc", int'(pc_enable_hbu), 0);
    chk("lu_bubble", int'(idex_bubble), 1);
    step();
    ex_reg_we = 0; ex_mem_rd = 0; ex_waddr = 0;
    mem_reg_we = 1; mem_mem_rd = 1; mem_waddr = 8; #1;
    chk("lu_stall_state", int'(ctrl_state), 1);
    step();
    mem_reg_we = 0; mem_mem_rd = 0; mem_waddr = 0; #1;
    chk("lu_resume_state", int'(ctrl_state), 0);
    chk("lu_resume_pc", int'(pc_enable_hbu), 1);
    step(); clear();

    // Load then taken beq $9,$0: two STALL cycles, then flush.
    ex_reg_we = 1; ex_mem_rd = 1; ex_waddr = 9;
    id_branch = 1; id_taken = 1; id_rs = 9; id_use_rs = 1; id_rt = 0; id_use_rt = 1; #1;
    chk("lb_bubble", int'(idex_bubble), 1);
    chk("lb_flush_held", int'(ifid_flush), 0);
    step();
    ex_reg_we = 0; ex_mem_rd = 0; ex_waddr = 0;
    mem_reg_we = 1; mem_mem_rd = 1; mem_waddr = 9; #1;
    chk("lb_stall1", int'(ctrl_state), 1);
    chk("lb_fwd_load", int'(fwd_br_a), 0);
    step();
    mem_reg_we = 0; mem_mem_rd = 0; mem_waddr = 0; #1;
    chk("lb_stall0", int'(ctrl_state), 1);
    step(); #1;
    chk("lb_run_flush", int'(ifid_flush), 1);
    chk("lb_run_fwd", int'(fwd_br_a), 0);
    step(); clear(); #1;
    chk("lb_flush_state", int'(ctrl_state), 2);
    chk("lb_flush_cycle_fl", int'(ifid_flush), 0);
    step(); #1;
    chk("lb_back_run", int'(ctrl_state), 0);

    // MEM ALU result forwarded to the branch comparator.
    mem_reg_we = 1; mem_waddr = 5;
    id_branch = 1; id_taken = 1; id_rs = 5; id_use_rs = 1; id_rt = 6; id_use_rt = 1; #1;
    chk("fw_a", int'(fwd_br_a), 1);
    chk("fw_b", int'(fwd_br_b), 0);
    chk("fw_flush", int'(ifid_flush), 1);
    chk("fw_no_bubble", int'(idex_bubble), 0);
    step(); clear(); #1;
    chk("fw_flush_state", int'(ctrl_state), 2);
    step();

    // Register 0 never matches.
    ex_reg_we = 1; ex_waddr = 0; id_rs = 0; id_use_rs = 1; id_branch = 1; #1;
    chk("r0_alu_bubble", int'(idex_bubble), 0);
    step();
    ex_mem_rd = 1; #1;
    chk("r0_load_bubble", int'(idex_bubble), 0);
    chk("r0_load_pc", int'(pc_enable_hbu), 1);
    step(); clear();

    // Run enable dropped mid-stall.
    ex_reg_we = 1; ex_mem_rd = 1; ex_waddr = 9; id_branch = 1; id_rs = 9; id_use_rs = 1; #1;
    chk("hs_detect", int'(idex_bubble), 1);
    step();
    ex_reg_we = 0; ex_mem_rd = 0; ex_waddr = 0; pc_enable = 0; #1;
    chk("hs_state", int'(ctrl_state), 1);
    chk("hs_bubble_off", int'(idex_bubble), 0);
    chk("hs_pc", int'(pc_enable_hbu), 0);
    step(); step(); #1;
    chk("hs_held3", int'(ctrl_state), 1);
    step();
    pc_enable = 1; #1;
    chk("hs_resume1", int'(idex_bubble), 1);
    step(); #1;
    chk("hs_resume0", int'(ctrl_state), 1);
    step(); #1;
    chk("hs_run", int'(ctrl_state), 0);
    chk("hs_run_pc", int'(pc_enable_hbu), 1);
    step(); clear();

    // HALT from RUN.
    pc_enable = 0; #1;
    chk("h_pc", int'(pc_enable_hbu), 0);
    step();
    pc_enable = 1; #1;
    chk("h_state", int'(ctrl_state), 3);
    chk("h_moore_pc", int'(pc_enable_hbu), 0);
    step(); #1;
    chk("h_back", int'(ctrl_state), 0);

    // Jump-register behind an EX ALU write: one stall, then redirect.
    ex_reg_we = 1; ex_waddr = 31; id_jump = 1; id_rs = 31; id_use_rs = 1; #1;
    chk("jr_bubble", int'(idex_bubble), 1);
    step();
    ex_reg_we = 0; ex_waddr = 0; #1;
    step(); #1;
    chk("jr_flush", int'(ifid_flush), 1);
    step(); clear(); step();

    // Branch behind a MEM load, and rt forwarding gated by id_branch.
    mem_reg_we = 1; mem_mem_rd = 1; mem_waddr = 4; id_branch = 1; id_rt = 4; id_use_rt = 1; #1;
    chk("ml_bubble", int'(idex_bubble), 1);
    chk("ml_fwd_b", int'(fwd_br_b), 0);
    step(); clear(); step(); step();
    mem_reg_we = 1; mem_waddr = 6; id_rt = 6; id_use_rt = 1; #1;
    chk("nb_fwd_b", int'(fwd_br_b), 0);
    id_branch = 1; #1;
    chk("br_fwd_b", int'(fwd_br_b), 1);
    step(); clear();

    // Reset mid-stall.
    ex_reg_we = 1; ex_mem_rd = 1; ex_waddr = 3; id_rs = 3; id_use_rs = 1; #1;
    step();
    clear(); p_rst_s = 1; #1;
    chk("rs_flush", int'(ifid_flush), 1);
    chk("rs_pc", int'(pc_enable_hbu), 0);
    step();
    p_rst_s = 0; #1;
    chk("rs_state", int'(ctrl_state), 0);
    chk("rs_pc_after", int'(pc_enable_hbu), 1);
    step(); step();

    run_cmp = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
